// File: rtl/seg_count_ctrl_pkg.sv
// Shared types and constants for the seven-segment count controller.
package seg_count_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } ctrl_state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] DIGIT_MIN = 4'd0;

endpackage

// File: rtl/seg_count_ctrl_if.sv
// Button inputs and decoder-facing outputs of the count controller.
interface seg_count_ctrl_if;
  logic       btn_run;
  logic       btn_step;
  logic       btn_dir;
  logic [3:0] digit;
  logic       tick;
  logic       running;
  logic       dir_down;

  modport master (
    output btn_run, btn_step, btn_dir,
    input  digit, tick, running, dir_down
  );

  modport slave (
    input  btn_run, btn_step, btn_dir,
    output digit, tick, running, dir_down
  );
endinterface

// File: rtl/seg_count_ctrl_btn_debounce.sv
// Two-flop synchroniser, counting debouncer and rising-edge press pulse for one button.
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic          sync_p0;
  logic          sync_p1;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      // synchroniser stage boundary
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      // debounce: a level is accepted only after DEB_CYCLES consecutive differing samples
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      level_q <= level;
      press   <= level & ~level_q;
    end
  end
endmodule

// File: rtl/seg_count_ctrl.sv
// Run/pause FSM, prescaler, direction flag and BCD digit register feeding the segment decoder.
module seg_count_ctrl
  import seg_count_pkg::*;
#(
  parameter int MAX_COUNT  = 10_000_000,
  parameter int DEB_CYCLES = 16
) (
  input logic              clk,
  input logic              rst,
  seg_count_ctrl_if.slave  bus
);
  localparam int PW = $clog2(MAX_COUNT);

  ctrl_state_t   state;
  ctrl_state_t   state_nx;
  logic          run_press;
  logic          step_press;
  logic          dir_press;
  logic          wrap;
  logic          step_tick;
  logic [PW-1:0] presc;
  logic [3:0]    digit_r;
  logic          tick_r;
  logic          dir_r;

  function automatic logic [3:0] next_digit(input logic [3:0] cur, input logic down);
    if (down) return (cur == DIGIT_MIN) ? DIGIT_MAX : cur - 4'd1;
    else      return (cur == DIGIT_MAX) ? DIGIT_MIN : cur + 4'd1;
  endfunction

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run  (.clk(clk), .rst(rst), .btn(bus.btn_run),  .press(run_press));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step (.clk(clk), .rst(rst), .btn(bus.btn_step), .press(step_press));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dir  (.clk(clk), .rst(rst), .btn(bus.btn_dir),  .press(dir_press));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  // a run press outranks a step press arriving in the same cycle
  always_comb begin
    state_nx  = state;
    wrap      = 1'b0;
    step_tick = 1'b0;
    case (state)
      RUN: begin
        wrap = (presc == PW'(MAX_COUNT - 1));
        if (run_press) state_nx = PAUSE;
      end
      PAUSE: begin
        if (run_press)       state_nx  = RUN;
        else if (step_press) step_tick = 1'b1;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      digit_r <= DIGIT_MIN;
      tick_r  <= 1'b0;
      dir_r   <= 1'b0;
    end else begin
      if (state == RUN) presc <= wrap ? '0 : presc + PW'(1);
      tick_r <= wrap | step_tick;
      // digit update uses the direction held before any same-cycle dir press
      if (wrap | step_tick) digit_r <= next_digit(digit_r, dir_r);
      if (dir_press) dir_r <= ~dir_r;
    end
  end

  assign bus.digit    = digit_r;
  assign bus.tick     = tick_r;
  assign bus.running  = (state == RUN);
  assign bus.dir_down = dir_r;
endmodule

// File: tb/tb_seg_count_ctrl.sv
// Self-checking bench for seg_count_ctrl with MAX_COUNT=100 and DEB_CYCLES=4.
module tb_seg_count_ctrl;
  localparam int MC = 100;

  typedef struct {
    int         edge_no;
    logic       btn_run;
    logic       btn_step;
    logic       btn_dir;
    logic [3:0] digit;
    logic       tick;
    logic       running;
    logic       dir_down;
  } vec_t;

  typedef struct {
    int edge_no;
    int digit;
  } exp_tick_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_n;
  int   checks = 0;
  int   errors = 0;
  int   ticks_seen = 0;
  exp_tick_t exp_q[$];
  vec_t vecs[8];

  seg_count_ctrl_if bus();

  seg_count_ctrl #(.MAX_COUNT(MC), .DEB_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    end
  endtask

  task automatic push_tick(input int e, input int d);
    exp_tick_t t;
    t.edge_no = e;
    t.digit   = d;
    exp_q.push_back(t);
  endtask

  task automatic flush_missed(input int before_edge);
    exp_tick_t t;
    while (exp_q.size() > 0 && exp_q[0].edge_no < before_edge) begin
      t = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_tick: got no tick at edge %0d, expected tick with digit %0d", t.edge_no, t.digit);
    end
  endtask

  task automatic tick_cycle();
    exp_tick_t t;
    @(posedge clk);
    #1;
    flush_missed(edge_n);
    if (bus.tick) begin
      ticks_seen++;
      if (exp_q.size() > 0 && exp_q[0].edge_no == edge_n) begin
        t = exp_q.pop_front();
        chk("tick_digit", int'(bus.digit), t.digit);
      end else begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick: got tick at edge %0d (digit %0d), expected none", edge_n, bus.digit);
      end
    end
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) tick_cycle();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_digit"},    int'(bus.digit),    0);
    chk({tag, "_tick"},     int'(bus.tick),     0);
    chk({tag, "_running"},  int'(bus.running),  1);
    chk({tag, "_dir_down"}, int'(bus.dir_down), 0);
  endtask

  task automatic apply_reset();
    flush_missed(32'h7fff_ffff);
    rst = 1'b1;
    bus.btn_run = 1'b0; bus.btn_step = 1'b0; bus.btn_dir = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit dropped;
    int t0;
    bus.btn_run = 1'b0; bus.btn_step = 1'b0; bus.btn_dir = 1'b0;
    vecs[0] = '{1,    1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{99,   1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{100,  1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{101,  1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{500,  1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{999,  1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1001, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};

    // free run
    apply_reset();
    for (int i = 1; i <= 10; i++) push_tick(i * MC, i % 10);
    for (int i = 0; i < 8; i++) begin
      run_to(vecs[i].edge_no - 1);
      bus.btn_run = vecs[i].btn_run; bus.btn_step = vecs[i].btn_step; bus.btn_dir = vecs[i].btn_dir;
      run_to(vecs[i].edge_no);
      chk("vec_digit",    int'(bus.digit),    int'(vecs[i].digit));
      chk("vec_tick",     int'(bus.tick),     int'(vecs[i].tick));
      chk("vec_running",  int'(bus.running),  int'(vecs[i].running));
      chk("vec_dir_down", int'(bus.dir_down), int'(vecs[i].dir_down));
    end

    // direction toggle, then counting down from 0
    apply_reset();
    push_tick(100, 9); push_tick(200, 8);
    run_to(49); bus.btn_dir = 1'b1;
    run_to(56); chk("dir_before", int'(bus.dir_down), 0);
    run_to(57); chk("dir_after", int'(bus.dir_down), 1);
    run_to(59); bus.btn_dir = 1'b0;
    run_to(210); chk("dir_held", int'(bus.dir_down), 1);

    // bounce rejection
    apply_reset();
    push_tick(100, 1); push_tick(200, 2);
    dropped = 1'b0;
    for (int i = 0; i < 20; i++) begin
      run_to(9 + i);
      bus.btn_run = ((i / 2) % 2) == 0;
      if (!bus.running) dropped = 1'b1;
    end
    bus.btn_run = 1'b0;
    while (edge_n < 210) begin
      tick_cycle();
      if (!bus.running) dropped = 1'b1;
    end
    chk("bounce_running_dropped", int'(dropped), 0);

    // pause with prescaler at 40, step, resume
    apply_reset();
    run_to(32); bus.btn_run = 1'b1;
    run_to(39); chk("pause_before", int'(bus.running), 1);
    run_to(40); chk("pause_after", int'(bus.running), 0);
    run_to(42); bus.btn_run = 1'b0;
    t0 = ticks_seen;
    run_to(540); chk("pause_tick_count", ticks_seen - t0, 0);
    push_tick(552, 1);
    run_to(544); bus.btn_step = 1'b1;
    run_to(554); bus.btn_step = 1'b0;
    run_to(600);
    chk("step_digit", int'(bus.digit), 1);
    chk("step_single", ticks_seen - t0, 1);
    push_tick(668, 2); push_tick(768, 3);
    bus.btn_run = 1'b1;
    run_to(607); chk("resume_before", int'(bus.running), 0);
    run_to(608); chk("resume_after", int'(bus.running), 1);
    run_to(610); bus.btn_run = 1'b0;
    run_to(775);

    // run and step together: in RUN, then in PAUSE
    apply_reset();
    run_to(19); bus.btn_run = 1'b1; bus.btn_step = 1'b1;
    run_to(26); chk("sim_run_before", int'(bus.running), 1);
    run_to(27); chk("sim_run_after", int'(bus.running), 0);
    run_to(29); bus.btn_run = 1'b0; bus.btn_step = 1'b0;
    t0 = ticks_seen;
    run_to(129);
    chk("sim_no_tick", ticks_seen - t0, 0);
    chk("sim_still_paused", int'(bus.running), 0);
    push_tick(210, 1);
    bus.btn_run = 1'b1; bus.btn_step = 1'b1;
    run_to(137); chk("sim_pause_resume", int'(bus.running), 1);
    run_to(139); bus.btn_run = 1'b0; bus.btn_step = 1'b0;
    run_to(215); chk("sim_pause_digit", int'(bus.digit), 1);

    // dir press coincident with tick, run press coincident with wrap
    apply_reset();
    push_tick(100, 1); push_tick(200, 0); push_tick(300, 9);
    run_to(92); bus.btn_dir = 1'b1;
    run_to(99); chk("coinc_dir_before", int'(bus.dir_down), 0);
    run_to(100); chk("coinc_dir_after", int'(bus.dir_down), 1);
    run_to(102); bus.btn_dir = 1'b0;
    run_to(292); bus.btn_run = 1'b1;
    run_to(300); chk("coinc_wrap_paused", int'(bus.running), 0);
    run_to(302); bus.btn_run = 1'b0;
    run_to(420); chk("coinc_final_digit", int'(bus.digit), 9);

    // asynchronous reset mid-cycle with digit 5 and prescaler at 40
    apply_reset();
    push_tick(100, 9); push_tick(200, 8); push_tick(300, 7); push_tick(400, 6); push_tick(500, 5);
    run_to(9); bus.btn_dir = 1'b1;
    run_to(19); bus.btn_dir = 1'b0;
    run_to(540);
    chk("areset_pre_digit", int'(bus.digit), 5);
    chk("areset_pre_dir", int'(bus.dir_down), 1);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_vals("areset");
    apply_reset();
    push_tick(100, 1);
    run_to(105);

    flush_missed(32'h7fff_ffff);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_count_ctrl.md
# seg_count_ctrl

Control stage directly upstream of the seven-segment decoder on the chip. It synchronises and debounces three push-buttons, and generates a prescaled one-cycle tick from the system clock. It maintains a decimal digit (0–9) that counts up or down and can be paused or single-stepped. The decoder consumes `digit`, and `tick` marks each update.

## Interface
Parameters:
- `MAX_COUNT`, default 10_000_000: clock cycles per tick in RUN; legal range ≥ 2.
- `DEB_CYCLES`, default 16: consecutive stable samples required to accept a button level; legal range ≥ 2.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset. One clock; reset is asynchronous and active-high.
- `btn_run` input 1: run/pause toggle button, asynchronous, active-high.
- `btn_step` input 1: single-step button, asynchronous, active-high.
- `btn_dir` input 1: direction toggle button, asynchronous, active-high.
- `digit` output 4: current digit, 0–9 BCD.
- `tick` output 1: one-cycle strobe, high in the cycle in which `digit` has just changed.
- `running` output 1: 1 = RUN, 0 = PAUSE.
- `dir_down` output 1: 0 = count up, 1 = count down.

## Operation
- **Button path:** each button passes through a 2-flop synchroniser, then a debouncer.
  - The debouncer's counter increments while the synchronised level differs from the accepted level, and clears when the levels match.
  - The accepted level updates when the counter has seen `DEB_CYCLES` differing samples.
  - A press pulse (one cycle) is generated on each rising edge of the accepted level.
- **State machine:** two states, RUN and PAUSE; reset state is RUN.
  - A run press toggles the state.
- **Direction:** a dir press toggles `dir_down`.
- **Prescaler:** width `$clog2(MAX_COUNT)`.
  - In RUN it counts 0..`MAX_COUNT`-1 and then wraps to 0; the wrap produces a tick.
  - In PAUSE it holds its value and is not cleared.
- **Step:** a step press in PAUSE produces exactly one tick and leaves the prescaler unchanged. A step press in RUN is ignored.
- **Digit update on tick:**
  - Up: 9→0, otherwise +1.
  - Down: 0→9, otherwise −1.
- **Simultaneous events:**
  - Run press and step press in the same cycle: the run press wins and the step is discarded.
  - Prescaler wrap in the same cycle as a run press (RUN→PAUSE): the tick is still issued.
  - Dir press in the same cycle as a tick: the tick uses the old direction.
- **Reset:** clears all state asynchronously, including synchronisers, debouncers, the prescaler and the press pulses.

## Timing
- Reset values: `digit`=0, `tick`=0, `running`=1, `dir_down`=0, prescaler=0. All debounced levels are 0.
- Edges are numbered from the first rising edge after `rst` deasserts, which is edge 1.
  - In RUN, the prescaler equals n mod `MAX_COUNT` after edge n.
  - `tick`=1 and `digit` update together at edges `MAX_COUNT`, 2·`MAX_COUNT`, …
- Button latency: a button held high from the edge that first samples it (edge k) has these effects:
  - The press pulse is active in the cycle after edge k+2+`DEB_CYCLES`.
  - `running`, `dir_down`, or `tick`/`digit` (for a step) change at edge k+3+`DEB_CYCLES`.
- A step produces exactly one `tick` cycle per accepted press. A held button does not repeat.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `seg_count_pkg` holds:
  - the `ctrl_state_t` enum {RUN, PAUSE};
  - constants `DIGIT_MAX`=4'd9 and `DIGIT_MIN`=4'd0.
- Sub-module `btn_debounce` (parameter `DEB_CYCLES`) contains the synchroniser, debouncer and rising-edge pulse. It is instantiated three times.
- The top level holds the FSM, prescaler, direction flag and digit register.

## Test plan
Bench parameters: `MAX_COUNT`=100, `DEB_CYCLES`=4, so button latency is k+7.
- **Free run:** no buttons after reset → `tick` pulses at edges 100, 200, …; `digit` steps 0→1→…→9, then reaches 0 again at edge 1000.
- **Direction:** `btn_dir` high for 10 cycles from edge k → `dir_down`=1 at edge k+7. Subsequent ticks take `digit` from 0→9→8.
- **Bounce rejection:** `btn_run` toggles every 2 cycles for 20 cycles, then goes low → `running` stays 1 and the tick cadence is unchanged.
- **Pause/step:**
  - Run press with the prescaler at 40 → `running`=0 and the prescaler holds at its current value.
  - No tick occurs for 500 cycles.
  - A step press gives exactly one tick and `digit`+1.
  - A second run press resumes; the next tick comes after the prescaler's remaining count.
- **Simultaneous:** run and step accepted on the same edge while in RUN → `running`=0 and no tick.
- **Async reset:** `rst` pulsed mid-cycle with `digit`=5 and the prescaler at 40 → outputs go to reset values without waiting for a clock edge. The first tick is 100 edges after release.
